// File: rtl/branch_ctrl_if.sv
// branch_ctrl_if: decode-side and PC/register-file-side signals of the B/BL
// sequencer.
//   master : decode stage; drives pc/instr/instr_valid/flags and observes
//            the redirect outputs
//   slave  : branch_ctrl itself
interface branch_ctrl_if;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  flags;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        lr_we;
  logic [31:0] lr_data;
  logic        flush;
  logic        busy;

  modport master (
    output pc, instr, instr_valid, flags,
    input  instr_ready, pc_load, pc_target, lr_we, lr_data, flush, busy
  );

  modport slave (
    input  pc, instr, instr_valid, flags,
    output instr_ready, pc_load, pc_target, lr_we, lr_data, flush, busy
  );
endinterface

// File: rtl/branch_ctrl.sv
// branch_ctrl: sequencer for ARM B/BL.
// Accepts one instruction per instr_valid/instr_ready handshake. Branches
// are latched and evaluated for one cycle against the captured NZCV flags.
// A taken branch pulses pc_load (and lr_we for BL) and holds flush for
// FLUSH_CYC cycles. Non-branch instructions are accepted and dropped.
//   clk, rst : clock, synchronous active-high reset
//   bus      : branch_ctrl_if.slave (instruction in, PC/LR redirect out)
module branch_ctrl #(
  parameter int unsigned FLUSH_CYC = 2
) (
  input logic     clk,
  input logic     rst,
  branch_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EVAL  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] pc_l;
  logic [3:0]  cond_l;
  logic        link_l;
  logic [23:0] imm_l;
  logic [3:0]  flags_l;

  logic        pc_load_r;
  logic        lr_we_r;
  logic        flush_r;
  logic [31:0] pc_target_r;
  logic [31:0] lr_data_r;

  logic        is_branch;
  logic        cond_pass;
  logic [31:0] offset;
  logic [31:0] target;

  assign is_branch = (bus.instr[27:25] == 3'b101);

  // Sign-extended word offset, pre-shifted by 2.
  assign offset = {{6{imm_l[23]}}, imm_l, 2'b00};
  assign target = pc_l + 32'd8 + offset;

  always_comb begin
    logic n, z, c, v;
    n = flags_l[3];
    z = flags_l[2];
    c = flags_l[1];
    v = flags_l[0];
    cond_pass = 1'b0;
    case (cond_l)
      4'h0: cond_pass = z;
      4'h1: cond_pass = !z;
      4'h2: cond_pass = c;
      4'h3: cond_pass = !c;
      4'h4: cond_pass = n;
      4'h5: cond_pass = !n;
      4'h6: cond_pass = v;
      4'h7: cond_pass = !v;
      4'h8: cond_pass = c && !z;
      4'h9: cond_pass = !c || z;
      4'hA: cond_pass = (n == v);
      4'hB: cond_pass = (n != v);
      4'hC: cond_pass = !z && (n == v);
      4'hD: cond_pass = z || (n != v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      pc_l        <= '0;
      cond_l      <= '0;
      link_l      <= 1'b0;
      imm_l       <= '0;
      flags_l     <= '0;
      pc_load_r   <= 1'b0;
      lr_we_r     <= 1'b0;
      flush_r     <= 1'b0;
      pc_target_r <= '0;
      lr_data_r   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // instr_ready is high whenever IDLE, so valid alone is a transfer.
          if (bus.instr_valid && is_branch) begin
            pc_l    <= bus.pc;
            cond_l  <= bus.instr[31:28];
            link_l  <= bus.instr[24];
            imm_l   <= bus.instr[23:0];
            flags_l <= bus.flags;
            state   <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (cond_pass) begin
            state       <= S_FLUSH;
            cnt         <= 4'(FLUSH_CYC);
            pc_load_r   <= 1'b1;
            pc_target_r <= target;
            lr_we_r     <= link_l;
            lr_data_r   <= pc_l + 32'd4;
            flush_r     <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_FLUSH: begin
          pc_load_r <= 1'b0;
          lr_we_r   <= 1'b0;
          cnt       <= cnt - 4'd1;
          // Leaving when the counter steps 1->0 keeps flush high for
          // exactly FLUSH_CYC cycles.
          if (cnt == 4'd1) begin
            state   <= S_IDLE;
            flush_r <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.instr_ready = (state == S_IDLE);
  assign bus.busy        = (state != S_IDLE);
  assign bus.pc_load     = pc_load_r;
  assign bus.lr_we       = lr_we_r;
  assign bus.flush       = flush_r;
  assign bus.pc_target   = pc_target_r;
  assign bus.lr_data     = lr_data_r;

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
Sequencer for the ARM B/BL datapath. Accepts one instruction per handshake and decodes B/BL. It evaluates the condition field against the NZCV flags and computes the branch target from the 24-bit signed offset (sign-extended to 32 bits, shifted left 2). On a taken branch it redirects the PC, optionally writes the link register, and holds a pipeline flush for a fixed number of cycles. It sits between decode and the PC/register-file write ports.

Parameters:
FLUSH_CYC, 2, cycles flush stays high after a taken branch (legal range 1..15)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
pc  input  32  address of the instruction presented on instr
instr  input  32  instruction word
instr_valid  input  1  instr/pc/flags are valid this cycle
instr_ready  output  1  controller can accept; high only in IDLE
flags  input  4  {N,Z,C,V}, sampled at acceptance
pc_load  output  1  one-cycle pulse: PC must load pc_target
pc_target  output  32  branch target address
lr_we  output  1  one-cycle pulse coincident with pc_load when L=1
lr_data  output  32  return address = accepted pc + 4
flush  output  1  squash younger instructions
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=1 at an edge): state goes to IDLE. pc_load, lr_we, flush, busy = 0. pc_target and lr_data = 0. instr_ready = 1 from the first cycle after reset.
- Reset also applies mid-operation (EVAL or FLUSH). The operation is abandoned and the next cycle shows reset values. No pc_load is issued for the abandoned branch.
- Accept rule: a transfer occurs at an edge where instr_valid=1 and instr_ready=1. instr_valid while instr_ready=0 is ignored, with no queuing.
- Decode: is_branch = (instr[27:25]==3'b101). L = instr[24]. cond = instr[31:28]. imm24 = instr[23:0].
- A non-branch instruction is accepted and dropped. The state stays IDLE and no outputs change.
- The following are latched on accepting a branch: pc, cond, L, imm24, flags. The state then goes to EVAL.
- EVAL (exactly 1 cycle):
  - offset = {{8{imm24[23]}}, imm24} << 2.
  - target = pc_l + 8 + offset, modulo 2^32 (carry out discarded).
- Condition table:
  - EQ Z; NE !Z; CS C; CC !C.
  - MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z.
  - GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; cond=1111 is treated as never.
- Condition pass: the state goes to FLUSH and the flush counter is loaded with FLUSH_CYC. At the same edge, these registers are set: pc_load=1, pc_target=target, lr_we=L, lr_data=pc_l+4, flush=1.
- Condition fail: the state returns to IDLE and all pulses stay 0.
- FLUSH:
  - pc_load and lr_we are high only in the first FLUSH cycle.
  - flush is high for exactly FLUSH_CYC cycles.
  - The counter decrements each cycle; when it reaches 0, the state goes to IDLE and flush drops.
  - pc_target and lr_data hold their values until the next taken branch.
- Latency, taken branch:
  - Acceptance at edge N; EVAL during cycle N..N+1.
  - pc_load/flush visible in the cycle after edge N+1.
  - instr_ready returns FLUSH_CYC cycles after that.
- Latency, not-taken branch: instr_ready returns 2 edges after acceptance.
- busy = !instr_ready. pc_load never asserts in two consecutive cycles.

Test Plan:
- BAL, pc=0x00001000, instr=0xEA000010, flags=0 -> pc_target=0x00001048; pc_load 1 cycle; lr_we=0; flush 2 cycles; ready back after flush.
- BL backward, pc=0x00002000, instr=0xEBFFFFFE -> pc_target=0x00002000; lr_we=1 with pc_load; lr_data=0x00002004.
- BEQ not taken, instr=0x0A000004, flags=4'b0000 -> no pc_load/lr_we/flush. Repeat with flags=4'b0100 -> taken, target=pc+0x18.
- Wrap, pc=0xFFFFFFF0, instr=0xEA000004 -> pc_target=0x00000008. GE: N=1,V=1 taken; LT: same flags not taken; cond=1111 never taken.
- rst pulsed during the second flush cycle -> next cycle all outputs 0, instr_ready=1. Back-to-back valid during busy is ignored (no second pc_load).
- Non-branch 0xE0811002 with instr_valid held high -> accepted every cycle, busy stays 0, no pulses.
